// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared types, key map lookups and LFSR taps for the keypad model
package keypad_pkg;

  typedef enum logic [1:0] {
    ST_IDLE           = 2'd0,
    ST_BOUNCE_PRESS   = 2'd1,
    ST_HELD           = 2'd2,
    ST_BOUNCE_RELEASE = 2'd3
  } state_e;

  // x^8 + x^6 + x^5 + x^4 + 1 as a Fibonacci tap mask over bits 7,5,4,3
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  // Rows: 1 2 3 A / 4 5 6 B / 7 8 9 C / E 0 F D
  function automatic logic [1:0] key_row(input logic [3:0] key);
    logic [1:0] row;
    case (key)
      4'h1, 4'h2, 4'h3, 4'hA: row = 2'd0;
      4'h4, 4'h5, 4'h6, 4'hB: row = 2'd1;
      4'h7, 4'h8, 4'h9, 4'hC: row = 2'd2;
      default:                row = 2'd3;
    endcase
    return row;
  endfunction

  function automatic logic [1:0] key_col(input logic [3:0] key);
    logic [1:0] col;
    case (key)
      4'h1, 4'h4, 4'h7, 4'hE: col = 2'd0;
      4'h2, 4'h5, 4'h8, 4'h0: col = 2'd1;
      4'h3, 4'h6, 4'h9, 4'hF: col = 2'd2;
      default:                col = 2'd3;
    endcase
    return col;
  endfunction

endpackage

// File: rtl/keypad_if.sv
// rtl/keypad_if.sv - command handshake and scanner row/column bundle for the keypad model
interface keypad_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_press;
  logic [3:0] cmd_key;
  logic [3:0] r;
  logic [3:0] c;
  logic       contact;
  logic [3:0] held_key;
  logic       busy;
  logic       cmd_err;

  modport master (
    output cmd_valid, cmd_press, cmd_key, r,
    input  cmd_ready, c, contact, held_key, busy, cmd_err
  );

  modport slave (
    input  cmd_valid, cmd_press, cmd_key, r,
    output cmd_ready, c, contact, held_key, busy, cmd_err
  );
endinterface

// File: rtl/lfsr8.sv
// rtl/lfsr8.sv - free-running 8-bit Fibonacci LFSR used as the contact chatter source
module lfsr8
  import keypad_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] seed,
  output logic [7:0] q
);

  logic [7:0] q_q;
  logic [7:0] q_d;

  always_comb begin
    q_d = {q_q[6:0], ^(q_q & LFSR_TAPS)};
  end

  // An all-zero state would lock up, so a zero seed is promoted to 1.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_q <= (seed == 8'h00) ? 8'h01 : seed;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/keypad_model.sv
// rtl/keypad_model.sv - behavioural 4x4 keypad switch with press/release bounce for scanner testing
module keypad_model
  import keypad_pkg::*;
#(
  parameter int unsigned BOUNCE_CYCLES = 16,
  parameter logic [7:0]  LFSR_SEED     = 8'hA5
) (
  input  logic    clk,
  input  logic    reset,
  keypad_if.slave kp
);

  localparam bit         NO_BOUNCE   = (BOUNCE_CYCLES == 0);
  localparam logic [7:0] BOUNCE_LOAD = NO_BOUNCE ? 8'd0 : 8'(BOUNCE_CYCLES - 1);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] key_q, key_d;
  logic       contact_q, contact_d;
  logic       err_q, err_d;
  logic [7:0] lfsr_q;
  logic       lfsr_unused;
  logic       accept;

  lfsr8 u_lfsr (
    .clk   (clk),
    .reset (reset),
    .seed  (LFSR_SEED),
    .q     (lfsr_q)
  );

  assign lfsr_unused = ^lfsr_q[7:1];

  assign kp.cmd_ready = (state_q == ST_IDLE) || (state_q == ST_HELD);
  assign kp.busy      = (state_q == ST_BOUNCE_PRESS) || (state_q == ST_BOUNCE_RELEASE);
  assign accept       = kp.cmd_valid && kp.cmd_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    key_d   = key_q;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (kp.cmd_press) begin
            key_d   = kp.cmd_key;
            state_d = NO_BOUNCE ? ST_HELD : ST_BOUNCE_PRESS;
            cnt_d   = BOUNCE_LOAD;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_HELD: begin
        if (accept) begin
          if (!kp.cmd_press && (kp.cmd_key == key_q)) begin
            state_d = NO_BOUNCE ? ST_IDLE : ST_BOUNCE_RELEASE;
            cnt_d   = BOUNCE_LOAD;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_BOUNCE_PRESS: begin
        if (cnt_q == 8'd0) begin
          state_d = ST_HELD;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: begin
        if (cnt_q == 8'd0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
    endcase

    // Contact follows the state being entered so it never lags the FSM.
    case (state_d)
      ST_IDLE: contact_d = 1'b0;
      ST_HELD: contact_d = 1'b1;
      default: contact_d = lfsr_q[0];
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 8'd0;
      key_q     <= 4'h0;
      contact_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      key_q     <= key_d;
      contact_q <= contact_d;
      err_q     <= err_d;
    end
  end

  assign kp.contact  = contact_q;
  assign kp.held_key = key_q;
  assign kp.cmd_err  = err_q;

  always_comb begin
    kp.c = 4'b0000;
    if (contact_q && kp.r[key_row(key_q)]) begin
      kp.c[key_col(key_q)] = 1'b1;
    end
  end

endmodule

// File: tb/tb_keypad_model.sv
// tb/tb_keypad_model.sv - randomized and directed self-checking bench for keypad_model
module tb_keypad_model;

  logic clk;
  logic s_reset;
  logic s_valid;
  logic s_press;
  logic [3:0] s_key;
  logic [3:0] s_r;

  int n_chk;
  int n_err;
  bit chk_en;

  keypad_if if0();
  keypad_if if1();
  keypad_if if2();

  assign if0.cmd_valid = s_valid; assign if0.cmd_press = s_press;
  assign if0.cmd_key   = s_key;   assign if0.r         = s_r;
  assign if1.cmd_valid = s_valid; assign if1.cmd_press = s_press;
  assign if1.cmd_key   = s_key;   assign if1.r         = s_r;
  assign if2.cmd_valid = s_valid; assign if2.cmd_press = s_press;
  assign if2.cmd_key   = s_key;   assign if2.r         = s_r;

  keypad_model #(.BOUNCE_CYCLES(0),  .LFSR_SEED(8'hA5)) dut0 (.clk(clk), .reset(s_reset), .kp(if0));
  keypad_model #(.BOUNCE_CYCLES(16), .LFSR_SEED(8'hA5)) dut1 (.clk(clk), .reset(s_reset), .kp(if1));
  keypad_model #(.BOUNCE_CYCLES(8),  .LFSR_SEED(8'h00)) dut2 (.clk(clk), .reset(s_reset), .kp(if2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, required finish before 400000");
    $fatal(1);
  end

  // Reference model: target closure, remaining bounce cycles, chatter source
  int         bc     [3];
  logic [7:0] seedf  [3];
  int         m_rem  [3];
  bit         m_pressed [3];
  logic [3:0] m_key  [3];
  bit         m_err  [3];
  logic [7:0] m_lfsr [3];
  bit         m_bbit [3];
  logic [3:0] keymap [16];
  bit         saw0, saw1;

  function automatic logic [7:0] lfsr_adv(input logic [7:0] x);
    return {x[6:0], x[7] ^ x[5] ^ x[4] ^ x[3]};
  endfunction

  function automatic int key_pos(input logic [3:0] k);
    int p;
    p = 0;
    for (int i = 0; i < 16; i++) if (keymap[i] == k) p = i;
    return p;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic model_step(input int i);
    bit acc, start;
    if (s_reset) begin
      m_rem[i] = 0; m_pressed[i] = 0; m_key[i] = 4'h0; m_err[i] = 0;
      m_lfsr[i] = seedf[i]; m_bbit[i] = 0;
    end else begin
      acc   = s_valid && (m_rem[i] == 0);
      start = 0;
      m_err[i] = 0;
      if (m_rem[i] > 0) m_rem[i]--;
      if (acc) begin
        if (s_press && !m_pressed[i]) begin
          m_key[i] = s_key; start = 1;
        end else if (!s_press && m_pressed[i] && s_key == m_key[i]) begin
          start = 1;
        end else begin
          m_err[i] = 1;
        end
        if (start) begin
          m_pressed[i] = !m_pressed[i];
          m_rem[i] = bc[i];
        end
      end
      m_bbit[i] = m_lfsr[i][0];
      m_lfsr[i] = lfsr_adv(m_lfsr[i]);
    end
  endtask

  task automatic cmp_inst(input int i, input logic rdy, input logic [3:0] c, input logic ct,
                          input logic [3:0] hk, input logic bs, input logic er, input logic [7:0] lf);
    logic       exp_ct;
    logic [3:0] exp_c;
    int         p;
    exp_ct = (m_rem[i] > 0) ? m_bbit[i] : m_pressed[i];
    p      = key_pos(m_key[i]);
    exp_c  = 4'b0000;
    if (exp_ct && s_r[p / 4]) exp_c[p % 4] = 1'b1;
    chk($sformatf("i%0d.cmd_ready", i), 32'(rdy), 32'(m_rem[i] == 0));
    chk($sformatf("i%0d.busy", i),      32'(bs),  32'(m_rem[i] > 0));
    chk($sformatf("i%0d.contact", i),   32'(ct),  32'(exp_ct));
    chk($sformatf("i%0d.c", i),         32'(c),   32'(exp_c));
    chk($sformatf("i%0d.held_key", i),  32'(hk),  32'(m_key[i]));
    chk($sformatf("i%0d.cmd_err", i),   32'(er),  32'(m_err[i]));
    chk($sformatf("i%0d.lfsr", i),      32'(lf),  32'(m_lfsr[i]));
  endtask

  task automatic tick();
    @(posedge clk);
    for (int i = 0; i < 3; i++) model_step(i);
    @(negedge clk);
    if (chk_en) begin
      cmp_inst(0, if0.cmd_ready, if0.c, if0.contact, if0.held_key, if0.busy, if0.cmd_err, dut0.u_lfsr.q);
      cmp_inst(1, if1.cmd_ready, if1.c, if1.contact, if1.held_key, if1.busy, if1.cmd_err, dut1.u_lfsr.q);
      cmp_inst(2, if2.cmd_ready, if2.c, if2.contact, if2.held_key, if2.busy, if2.cmd_err, dut2.u_lfsr.q);
      if (if2.busy) begin
        if (if2.contact) saw1 = 1; else saw0 = 1;
      end
    end
  endtask

  task automatic do_reset();
    s_reset = 1; s_valid = 0;
    tick();
    s_reset = 0;
  endtask

  task automatic send(input bit press, input logic [3:0] key);
    s_valid = 1; s_press = press; s_key = key;
    tick();
    s_valid = 0;
  endtask

  task automatic wait_ready();
    int k;
    for (k = 0; k < 40; k++) begin
      if (if0.cmd_ready && if1.cmd_ready && if2.cmd_ready) break;
      tick();
    end
    chk("wait_ready", 32'(if0.cmd_ready && if1.cmd_ready && if2.cmd_ready), 32'd1);
  endtask

  initial begin
    int busy_cnt;
    bit ready_bad;
    n_chk = 0; n_err = 0; chk_en = 1; saw0 = 0; saw1 = 0;
    bc[0] = 0;  bc[1] = 16; bc[2] = 8;
    seedf[0] = 8'hA5; seedf[1] = 8'hA5; seedf[2] = 8'h01;
    keymap = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
               4'h7, 4'h8, 4'h9, 4'hC, 4'hE, 4'h0, 4'hF, 4'hD};
    s_reset = 1; s_valid = 0; s_press = 0; s_key = 4'h0; s_r = 4'b0000;

    // Reset state and zero-seed promotion
    do_reset();
    chk("rst.c", 32'(if0.c), 32'h0);
    chk("rst.held_key", 32'(if1.held_key), 32'h0);
    chk("rst.ready", 32'(if1.cmd_ready), 32'h1);
    chk("seed0.lfsr", 32'(dut2.u_lfsr.q), 32'h01);

    // No-bounce press/release timing
    s_r = 4'b0010;
    send(1, 4'h5);
    chk("nb.press_c", 32'(if0.c), 32'b0010);
    tick(); tick(); tick();
    chk("nb.hold_c", 32'(if0.c), 32'b0010);
    send(0, 4'h5);
    chk("nb.release_c", 32'(if0.c), 32'h0);

    // 16-cycle bounce on key D
    do_reset();
    s_r = 4'b1000;
    send(1, 4'hD);
    busy_cnt = 0; ready_bad = 0;
    for (int k = 0; k < 40; k++) begin
      if (if1.busy) begin
        busy_cnt++;
        if (if1.cmd_ready) ready_bad = 1;
      end
      tick();
    end
    chk("b16.busy_cycles", 32'(busy_cnt), 32'd16);
    chk("b16.ready_low", 32'(ready_bad), 32'd0);
    chk("b16.held_c", 32'(if1.c), 32'b1000);

    // Illegal commands
    do_reset();
    send(1, 4'h7);
    wait_ready();
    send(0, 4'h3);
    chk("ill.err_pulse", 32'(if0.cmd_err), 32'h1);
    tick();
    chk("ill.err_clear", 32'(if0.cmd_err), 32'h0);
    chk("ill.still_held", 32'(if1.contact && if1.cmd_ready), 32'h1);
    send(0, 4'h7);
    wait_ready();
    send(0, 4'h3);
    chk("ill.idle_err", 32'(if1.cmd_err), 32'h1);
    tick();
    chk("ill.idle_clear", 32'(if1.cmd_err), 32'h0);

    // Row sweep with key A held
    do_reset();
    s_r = 4'b0000;
    send(1, 4'hA);
    wait_ready();
    for (int k = 0; k < 4; k++) begin
      s_r = 4'(1 << k);
      tick();
      chk($sformatf("sweep.r%0d", k), 32'(if0.c), (k == 0) ? 32'b1000 : 32'b0000);
    end

    // Reset during the fifth press-bounce cycle
    do_reset();
    s_r = 4'b1111;
    send(1, 4'h9);
    tick(); tick(); tick(); tick();
    chk("rmb.in_bounce", 32'(if1.busy), 32'h1);
    s_reset = 1;
    tick();
    s_reset = 0;
    chk("rmb.contact", 32'(if1.contact), 32'h0);
    chk("rmb.c", 32'(if1.c), 32'h0);
    chk("rmb.held_key", 32'(if1.held_key), 32'h0);
    chk("rmb.idle", 32'(if1.cmd_ready && !if1.busy), 32'h1);

    // Randomized traffic against the model
    for (int n = 0; n < 1500; n++) begin
      s_reset = ($urandom_range(0, 99) == 0);
      s_valid = $urandom_range(0, 1);
      s_press = $urandom_range(0, 1);
      case ($urandom_range(0, 5))
        0: s_key = 4'h5;
        1: s_key = 4'h7;
        2: s_key = 4'hA;
        3: s_key = 4'hD;
        default: s_key = 4'($urandom_range(0, 15));
      endcase
      s_r = 4'($urandom_range(0, 15));
      tick();
    end
    s_reset = 0; s_valid = 0;

    chk("seed0.chatter_varies", 32'(saw0 && saw1), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
